// File: rtl/alu_mult_seq.sv
// alu_mult_seq
// Multi-cycle MULT/MULTU sequencer that borrows the execute-stage ALU as its
// only adder. Signed operands are reduced to magnitudes, multiplied by
// shift-and-add (one ALU add per multiplier bit) and the 2N-bit product is
// negated back when the operand signs differ.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : request, sampled only while idle
//   signed_op             : 1 = MULT (two's complement), 0 = MULTU
//   op_a, op_b            : multiplicand / multiplier, sampled with start
//   busy                  : high in every state except IDLE
//   done                  : one-cycle pulse when hi/lo are final
//   hi, lo                : product words, held until the next accepted start
//   alu_a, alu_b          : ALU operand drive
//   alu_control           : ALU opcode drive (ADDU or SUBU only)
//   alu_out, alu_cout     : combinational ALU result and carry/borrow bit
`timescale 1ns/1ps
module alu_mult_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int OP_SIZE    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  signed_op,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [OP_SIZE-1:0]    alu_control,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_cout
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [OP_SIZE-1:0] ALU_ADDU = OP_SIZE'(14);
    localparam logic [OP_SIZE-1:0] ALU_SUBU = OP_SIZE'(13);
    localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABS_A  = 3'd1,
        ST_ABS_B  = 3'd2,
        ST_ITER   = 3'd3,
        ST_NEG_LO = 3'd4,
        ST_NEG_HI = 3'd5,
        ST_FIX_HI = 3'd6,
        ST_DONE   = 3'd7
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic                  borrow_q, borrow_d;
    logic                  sgn_q, sgn_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] alu_a_s;
    logic [DATA_WIDTH-1:0] alu_b_s;
    logic [OP_SIZE-1:0]    alu_ctl_s;

    // Next-state, datapath updates and ALU drive for the current state.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        borrow_d  = borrow_q;
        sgn_d     = sgn_q;
        alu_a_s   = ZERO_W;
        alu_b_s   = ZERO_W;
        alu_ctl_s = ALU_ADDU;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d = op_a;
                    lo_d    = op_b;
                    hi_d    = ZERO_W;
                    cnt_d   = {CNT_W{1'b0}};
                    sgn_d   = signed_op;
                    neg_d   = signed_op & (op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1]);
                    state_d = signed_op ? ST_ABS_A : ST_ITER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABS_A: begin
                // 0 - x; the most negative value maps to itself, which is
                // still the right unsigned magnitude.
                alu_ctl_s = ALU_SUBU;
                alu_b_s   = mcand_q;
                if (mcand_q[DATA_WIDTH-1]) begin
                    mcand_d = alu_out;
                end else begin
                    mcand_d = mcand_q;
                end
                state_d = ST_ABS_B;
            end
            ST_ABS_B: begin
                alu_ctl_s = ALU_SUBU;
                alu_b_s   = lo_q;
                if (lo_q[DATA_WIDTH-1]) begin
                    lo_d = alu_out;
                end else begin
                    lo_d = lo_q;
                end
                state_d = ST_ITER;
            end
            ST_ITER: begin
                // Add the multiplicand when the current multiplier bit is set,
                // then shift {carry, hi, lo} right by one.
                alu_ctl_s = ALU_ADDU;
                alu_a_s   = hi_q;
                alu_b_s   = lo_q[0] ? mcand_q : ZERO_W;
                hi_d      = {alu_cout, alu_out[DATA_WIDTH-1:1]};
                lo_d      = {alu_out[0], lo_q[DATA_WIDTH-1:1]};
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = sgn_q ? ST_NEG_LO : ST_DONE;
                end else begin
                    state_d = ST_ITER;
                end
            end
            ST_NEG_LO: begin
                // Borrow out of 0 - lo is 1 exactly when lo is nonzero; it is
                // the borrow into the upper word of the 2N-bit negation.
                alu_ctl_s = ALU_SUBU;
                alu_b_s   = lo_q;
                if (neg_q) begin
                    lo_d     = alu_out;
                    borrow_d = alu_cout;
                end else begin
                    borrow_d = 1'b0;
                end
                state_d = ST_NEG_HI;
            end
            ST_NEG_HI: begin
                alu_ctl_s = ALU_SUBU;
                alu_b_s   = hi_q;
                if (neg_q) begin
                    hi_d = alu_out;
                end else begin
                    hi_d = hi_q;
                end
                state_d = ST_FIX_HI;
            end
            ST_FIX_HI: begin
                alu_ctl_s = ALU_SUBU;
                alu_a_s   = hi_q;
                alu_b_s   = {{(DATA_WIDTH-1){1'b0}}, borrow_q};
                if (neg_q) begin
                    hi_d = alu_out;
                end else begin
                    hi_d = hi_q;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mcand_q  <= ZERO_W;
            hi_q     <= ZERO_W;
            lo_q     <= ZERO_W;
            cnt_q    <= {CNT_W{1'b0}};
            neg_q    <= 1'b0;
            borrow_q <= 1'b0;
            sgn_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            borrow_q <= borrow_d;
            sgn_q    <= sgn_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    // ALU drive must be same-cycle so the adder result lands in the state
    // registers on the next edge.
    assign alu_a       = alu_a_s;
    assign alu_b       = alu_b_s;
    assign alu_control = alu_ctl_s;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Directed self-checking bench for alu_mult_seq with a behavioural ADDU/SUBU
// ALU model closing the loop.
`timescale 1ns/1ps
module tb_alu_mult_seq;
    localparam int N = 16;
    localparam logic [3:0] ADDU = 4'd14;
    localparam logic [3:0] SUBU = 4'd13;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          signed_op = 1'b0;
    logic [N-1:0]  op_a = 16'h0000;
    logic [N-1:0]  op_b = 16'h0000;
    logic          busy, done;
    logic [N-1:0]  hi, lo, alu_a, alu_b, alu_out;
    logic [3:0]    alu_control;
    logic          alu_cout;
    logic [N:0]    pre_s;

    int n_checks = 0;
    int n_errors = 0;

    alu_mult_seq #(.DATA_WIDTH(N), .OP_SIZE(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .alu_a(alu_a), .alu_b(alu_b),
        .alu_control(alu_control), .alu_out(alu_out), .alu_cout(alu_cout)
    );

    // ALU model: pre_out is N+1 bits, carry/borrow is its top bit.
    always_comb begin
        if (alu_control == SUBU) pre_s = {1'b0, alu_a} - {1'b0, alu_b};
        else                     pre_s = {1'b0, alu_a} + {1'b0, alu_b};
    end
    assign alu_out  = pre_s[N-1:0];
    assign alu_cout = pre_s[N];

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation from an IDLE cycle (called at a negedge), wait for
    // done, check latency/busy/result, then check the following IDLE cycle.
    // poke pulses start at cycles 5, 10 and in the DONE cycle with garbage
    // operands; all three must be ignored.
    task automatic run_op(input string tag, input logic sgn, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] exp_hi,
                          input logic [N-1:0] exp_lo, input int exp_lat, input bit poke);
        int  cyc = 0;
        int  busy_cyc = 0;
        bit  seen = 1'b0;
        signed_op = sgn; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op_a = 16'hDEAD; op_b = 16'hBEEF; signed_op = ~sgn;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cyc++;
            if (done) begin
                seen = 1'b1;
                start = poke;
            end else if (poke && (cyc == 5 || cyc == 10)) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check_eq({tag, " done_seen"}, 32'(seen), 32'd1);
        check_eq({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check_eq({tag, " busy_cycles"}, 32'(busy_cyc), 32'(exp_lat));
        check_eq({tag, " hi"}, 32'(hi), 32'(exp_hi));
        check_eq({tag, " lo"}, 32'(lo), 32'(exp_lo));
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, " idle_busy"}, 32'(busy), 32'd0);
        check_eq({tag, " idle_done"}, 32'(done), 32'd0);
        check_eq({tag, " hold_hi"}, 32'(hi), 32'(exp_hi));
        check_eq({tag, " hold_lo"}, 32'(lo), 32'(exp_lo));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst done", 32'(done), 32'd0);
        check_eq("rst hi", 32'(hi), 32'd0);
        check_eq("rst lo", 32'(lo), 32'd0);
        check_eq("rst alu_a", 32'(alu_a), 32'd0);
        check_eq("rst alu_b", 32'(alu_b), 32'd0);
        check_eq("rst alu_ctl", 32'(alu_control), 32'(ADDU));
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back operations: each starts in the IDLE cycle after DONE.
        run_op("multu_ffff_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 17, 1'b0);
        run_op("mult_m3_5",       1'b1, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 22, 1'b0);
        run_op("mult_7_6",        1'b1, 16'h0007, 16'h0006, 16'h0000, 16'h002A, 22, 1'b0);
        run_op("mult_min_min",    1'b1, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 22, 1'b0);
        run_op("mult_min_1",      1'b1, 16'h8000, 16'h0001, 16'hFFFF, 16'h8000, 22, 1'b0);
        run_op("mult_m1_0",       1'b1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 22, 1'b0);
        run_op("multu_0_1234",    1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 17, 1'b0);
        run_op("multu_poke",      1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 17, 1'b1);
        run_op("mult_m1_m1",      1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 22, 1'b0);

        // Reset in the middle of ITER aborts immediately.
        signed_op = 1'b0; op_a = 16'h00FF; op_b = 16'h00FF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst busy", 32'(busy), 32'd0);
        check_eq("midrst done", 32'(done), 32'd0);
        check_eq("midrst hi", 32'(hi), 32'd0);
        check_eq("midrst lo", 32'(lo), 32'd0);
        check_eq("midrst alu_a", 32'(alu_a), 32'd0);
        check_eq("midrst alu_b", 32'(alu_b), 32'd0);
        check_eq("midrst alu_ctl", 32'(alu_control), 32'(ADDU));
        repeat (3) @(negedge clk);
        check_eq("midrst held_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst done", 32'(done), 32'd0);
        run_op("multu_3_4", 1'b0, 16'h0003, 16'h0004, 16'h0000, 16'h000C, 17, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_mult_seq.md
# alu_mult_seq

Multi-cycle multiply sequencer that reuses the existing combinational ALU as its only adder, computing MULT/MULTU results into HI/LO by shift-and-add. The block sits beside the ALU in the execute stage. While a multiply is in progress it owns the ALU operand/control inputs, and the pipeline stalls on `busy`. Each ALU operation the block issues is one of the ALU's existing ADDU/SUBU codes; no new ALU datapath is required.

## Interface
- `DATA_WIDTH`, 16 — operand width N; HI/LO are each N bits.
- `OP_SIZE`, 4 — ALU control field width.
- `clk` input 1 — single clock; all state updates on rising edge.
- `rst_n` input 1 — reset, asynchronous, active-low.
- `start` input 1 — request; sampled only in IDLE.
- `signed_op` input 1 — 1 = MULT (two's complement), 0 = MULTU; sampled with `start`.
- `op_a` input N — multiplicand; sampled with `start`.
- `op_b` input N — multiplier; sampled with `start`.
- `busy` output 1 — high in every state except IDLE.
- `done` output 1 — one-cycle pulse when HI/LO are final.
- `hi` output N — upper product word.
- `lo` output N — lower product word.
- `alu_a` output N — drives ALU `rega`.
- `alu_b` output N — drives ALU `regb`.
- `alu_control` output OP_SIZE — drives ALU `control`; only ADDU (4'd14) and SUBU (4'd13) are issued.
- `alu_out` input N — ALU result, same cycle (combinational).
- `alu_cout` input 1 — ALU carry/borrow bit, pre_out[N].

## Operation
- Internal registers: `mcand` (N), `hi`, `lo`, `cnt` (enough bits for 0..N-1), `neg` (1), `borrow` (1), state.
- States: IDLE, ABS_A, ABS_B, ITER, NEG_LO, NEG_HI, FIX_HI, DONE.
- IDLE:
  - ALU drive is `alu_a=0`, `alu_b=0`, ADDU.
  - When `start=1`: `mcand<=op_a`, `lo<=op_b`, `hi<=0`, `cnt<=0`, `neg<=signed_op & (op_a[N-1]^op_b[N-1])`.
  - Next state is ABS_A if `signed_op`, else ITER.
- ABS_A: ALU performs SUBU with a=0, b=`mcand`. If `mcand[N-1]`, then `mcand<=alu_out`. Next state ABS_B.
- ABS_B: same as ABS_A but applied to `lo`. Next state ITER.
- ITER:
  - ALU performs ADDU with a=`hi`, b=(`lo[0]` ? `mcand` : 0).
  - Register update: `hi<={alu_cout, alu_out[N-1:1]}`, `lo<={alu_out[0], lo[N-1:1]}`, `cnt<=cnt+1`.
  - Exits after N iterations (`cnt==N-1`): to NEG_LO if `signed_op` latched, else DONE.
- NEG_LO: ALU performs SUBU with a=0, b=`lo`. If `neg`, then `lo<=alu_out` and `borrow<=alu_cout` (1 iff lo≠0); otherwise `borrow<=0`.
- NEG_HI: ALU performs SUBU with a=0, b=`hi`. If `neg`, then `hi<=alu_out`.
- FIX_HI: ALU performs SUBU with a=`hi`, b={0…0,`borrow`}. If `neg`, then `hi<=alu_out`. Next state DONE.
- Signed runs always pass through all three NEG states, writing only when `neg=1`, so signed latency is fixed.
- DONE: `done=1` for one cycle. Next state IDLE.
- `hi`/`lo` hold their value from DONE until the next accepted `start`.
- Arithmetic rules:
  - Magnitudes are treated as unsigned N-bit values. The most negative value (e.g. 0x8000) negates to itself and is correct as magnitude 2^(N-1).
  - The 2N-bit product never overflows.
  - A zero product with `neg=1` must yield 0: borrow=0, so HI = 0−0−0.
- The block ignores the ALU `overflow`, `zero` and `equal` outputs.

## Timing
- Reset (asynchronous, `rst_n=0`): state=IDLE; `busy=0`, `done=0`, `hi=0`, `lo=0`, `alu_a=0`, `alu_b=0`, `alu_control=ADDU`; `neg=0`, `borrow=0`, `cnt=0`.
- Reset asserted mid-operation aborts immediately. No `done` is produced.
- Latency from the edge that samples `start` to the `done` cycle:
  - MULTU: N+1 cycles (17 for N=16).
  - MULT: N+6 cycles (22 for N=16).
- `busy` rises the cycle after `start` is accepted and falls together with leaving DONE. `busy=1` during DONE.
- `start` while busy (including the DONE cycle) is ignored, with no queuing.
- `start` on the first IDLE cycle after DONE is accepted: back-to-back operations have zero idle gap beyond that one IDLE cycle.
- ALU outputs are registered-state-derived combinational signals. The ALU path must close in one cycle: state regs → ALU → state regs.

## Test plan
- MULTU 0xFFFF × 0xFFFF (N=16) -> `done` 17 cycles after start; hi=0xFFFE, lo=0x0001; `busy` high for exactly 17 cycles.
- MULT −3 (0xFFFD) × 5 -> `done` at cycle 22; hi=0xFFFF, lo=0xFFF1. MULT 7 × 6 -> hi=0x0000, lo=0x002A, also at cycle 22.
- MULT 0x8000 × 0x8000 -> hi=0x4000, lo=0x0000. MULT 0x8000 × 0x0001 -> hi=0xFFFF, lo=0x8000.
- MULT 0xFFFF × 0x0000 (neg=1, zero product) -> hi=0x0000, lo=0x0000. MULTU 0 × 0x1234 -> zeros.
- `start` pulsed at cycles 5 and 10 of an active MULTU -> second request ignored, a single `done`, result unchanged. A new `start` in the IDLE cycle after `done` is accepted.
- `rst_n` low at ITER cycle 8 -> outputs at reset values immediately, no `done`. After release, MULTU 3 × 4 gives lo=0x000C, hi=0.
